// File: rtl/uart_trx_if.sv
// Byte-level and serial-line signals of the uart_trx block.
// The master modport is the user/line side; the slave modport is the block itself.
interface uart_trx_if;
    logic       En_Tx;
    logic [7:0] data_in;
    logic       Tx_Active;
    logic       serial_out;
    logic       Tx_Done;
    logic       serial_in;
    logic [7:0] data_out;
    logic       Rx_Done;

    modport master (
        output En_Tx, data_in, serial_in,
        input  Tx_Active, serial_out, Tx_Done, data_out, Rx_Done
    );

    modport slave (
        input  En_Tx, data_in, serial_in,
        output Tx_Active, serial_out, Tx_Done, data_out, Rx_Done
    );
endinterface

// File: rtl/uart_trx.sv
// 8N1 UART transceiver: independent transmitter and receiver sharing one clock.
// The receiver samples mid-bit, timed from the synchronized start-bit falling edge.
module uart_trx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_trx_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP
    } rx_state_t;

    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [2:0]       tx_idx_nxt;
    logic [7:0]       tx_byte;
    logic             tx_line;
    logic             tx_active;
    logic             tx_done;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic             rx_meta;
    logic             rx_sync;

    assign tx_idx_nxt = tx_idx + 3'd1;

    // Transmitter: start, 8 data bits LSB first, stop, then a one-cycle done state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_byte   <= '0;
            tx_line   <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    tx_line <= 1'b1;
                    if (bus.En_Tx) begin
                        tx_byte   <= bus.data_in;
                        tx_active <= 1'b1;
                        tx_line   <= 1'b0;
                        tx_cnt    <= '0;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_line  <= tx_byte[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_idx  <= tx_idx_nxt;
                            tx_line <= tx_byte[tx_idx_nxt];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        tx_active <= 1'b0;
                        tx_done   <= 1'b1;
                        tx_state  <= TX_DONE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DONE: begin
                    tx_line  <= 1'b1;
                    tx_state <= TX_IDLE;
                end
                default: begin
                    tx_line   <= 1'b1;
                    tx_active <= 1'b0;
                    tx_state  <= TX_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.serial_in;
            rx_sync <= rx_meta;
        end
    end

    // Receiver: confirm start bit at its midpoint, then sample every bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt           <= '0;
                        rx_shift[rx_idx] <= rx_sync;
                        if (rx_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            rx_data <= rx_shift;
                            rx_done <= 1'b1;
                        end
                        rx_state <= RX_CLEANUP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_CLEANUP: begin
                    // A line still held low after the frame must not restart reception.
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign bus.Tx_Active  = tx_active;
    assign bus.serial_out = tx_line;
    assign bus.Tx_Done    = tx_done;
    assign bus.data_out   = rx_data;
    assign bus.Rx_Done    = rx_done;

endmodule

// File: tb/tb_uart_trx.sv
// Self-checking bench for uart_trx: frame-level reference model of the serial
// waveform and of the last valid received byte, with randomized bytes and bit timing.
module tb_uart_trx;

    localparam int C = 434;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_line;
    logic loop_en;

    uart_trx_if ifc ();

    assign ifc.serial_in = loop_en ? ifc.serial_out : rx_line;

    uart_trx #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc = 0;
    int rx_done_cnt = 0;
    int tx_done_cnt = 0;
    int rx_done_cyc = 0;
    logic [7:0] exp_data;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.Rx_Done === 1'b1) begin
            rx_done_cnt <= rx_done_cnt + 1;
            rx_done_cyc <= cyc;
        end
        if (ifc.Tx_Done === 1'b1) tx_done_cnt <= tx_done_cnt + 1;
    end

    // Line level of bit i (0 = start, 1..8 = data LSB first, 9 = stop) of an 8N1 frame.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return d[i-1];
    endfunction

    // Sends a byte; optionally pokes En_Tx mid-frame and during the done cycle.
    task automatic tx_frame(input logic [7:0] d, input bit poke, input bit poke_done);
        int poke_at;
        int n0;
        bit ok;
        logic exp;
        logic [2:0] bad;
        poke_at = int'($urandom_range(10*C - 2, 1));
        n0 = tx_done_cnt;
        ifc.En_Tx   = 1'b1;
        ifc.data_in = d;
        @(negedge clk);
        ifc.En_Tx   = 1'b0;
        ifc.data_in = 8'($urandom);
        for (int b = 0; b < 10; b++) begin
            ok  = 1'b1;
            exp = frame_bit(d, b);
            bad = 3'b000;
            for (int k = 0; k < C; k++) begin
                if (ok && (ifc.serial_out !== exp || ifc.Tx_Active !== 1'b1 || ifc.Tx_Done !== 1'b0)) begin
                    ok  = 1'b0;
                    bad = {ifc.serial_out, ifc.Tx_Active, ifc.Tx_Done};
                end
                if (poke && (b*C + k) == poke_at) begin
                    ifc.En_Tx   = 1'b1;
                    ifc.data_in = 8'h00;
                end else begin
                    ifc.En_Tx = 1'b0;
                end
                @(negedge clk);
            end
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL tx_bit%0d byte=%02h: line/active/done=%b required %b10", b, d, bad, exp);
            end
        end
        vectors++;
        if ({ifc.Tx_Done, ifc.Tx_Active, ifc.serial_out} !== 3'b101) begin
            errors++;
            $display("FAIL tx_done_cycle byte=%02h: done/active/line=%b required 101", d,
                     {ifc.Tx_Done, ifc.Tx_Active, ifc.serial_out});
        end
        if (poke_done) begin
            ifc.En_Tx   = 1'b1;
            ifc.data_in = ~d;
        end
        @(negedge clk);
        ifc.En_Tx = 1'b0;
        vectors++;
        if ({ifc.Tx_Done, ifc.Tx_Active, ifc.serial_out} !== 3'b001) begin
            errors++;
            $display("FAIL tx_after_done byte=%02h: done/active/line=%b required 001", d,
                     {ifc.Tx_Done, ifc.Tx_Active, ifc.serial_out});
        end
        vectors++;
        if (tx_done_cnt - n0 !== 1) begin
            errors++;
            $display("FAIL tx_done_count byte=%02h: %0d pulses required 1", d, tx_done_cnt - n0);
        end
    endtask

    // Drives one frame on the receive line and checks it against the model.
    task automatic rx_frame(input logic [7:0] d, input int start_len, input int bit_len,
                            input int jitter, input bit stop_val);
        int n0;
        int len;
        int stop_start;
        n0 = rx_done_cnt;
        rx_line = 1'b0;
        repeat (start_len) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx_line = d[b];
            len = bit_len + int'($urandom_range(2*jitter, 0)) - jitter;
            repeat (len) @(negedge clk);
        end
        stop_start = cyc;
        rx_line = stop_val;
        repeat (bit_len) @(negedge clk);
        if (stop_val) exp_data = d;
        vectors++;
        if (rx_done_cnt - n0 !== (stop_val ? 1 : 0)) begin
            errors++;
            $display("FAIL rx_done_count byte=%02h stop=%b: %0d pulses required %0d", d, stop_val,
                     rx_done_cnt - n0, stop_val ? 1 : 0);
        end
        vectors++;
        if (ifc.data_out !== exp_data) begin
            errors++;
            $display("FAIL rx_data byte=%02h stop=%b: data_out=%02h required %02h", d, stop_val,
                     ifc.data_out, exp_data);
        end
        if (stop_val) begin
            vectors++;
            if (rx_done_cyc < stop_start || rx_done_cyc >= stop_start + bit_len) begin
                errors++;
                $display("FAIL rx_done_window byte=%02h: pulse at %0d required in [%0d,%0d)", d,
                         rx_done_cyc, stop_start, stop_start + bit_len);
            end
        end else begin
            repeat (300) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.En_Tx = 1'b0;
        ifc.data_in = 8'h00;
        rx_line = 1'b1;
        loop_en = 1'b0;
        exp_data = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ifc.serial_out, ifc.Tx_Active, ifc.Tx_Done, ifc.Rx_Done, ifc.data_out} !== {4'b1000, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: line/active/txd/rxd/data=%b required 1000_00000000",
                     {ifc.serial_out, ifc.Tx_Active, ifc.Tx_Done, ifc.Rx_Done, ifc.data_out});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({ifc.serial_out, ifc.Tx_Active, ifc.Tx_Done, ifc.Rx_Done} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_after_reset: line/active/txd/rxd=%b required 1000",
                     {ifc.serial_out, ifc.Tx_Active, ifc.Tx_Done, ifc.Rx_Done});
        end
    endtask

    task automatic test_tx_basic();
        tx_frame(8'h9F, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_tx_ignore_and_back_to_back();
        tx_frame(8'hFF, 1'b1, 1'b1);
        tx_frame(8'($urandom), 1'b1, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_rx_basic();
        rx_frame(8'h8F, C + 50, C - 1, 0, 1'b1);
    endtask

    task automatic test_rx_glitch();
        int n0;
        n0 = rx_done_cnt;
        rx_line = 1'b0;
        repeat (100) @(negedge clk);
        rx_line = 1'b1;
        repeat (600) @(negedge clk);
        vectors++;
        if (rx_done_cnt != n0 || ifc.data_out !== exp_data) begin
            errors++;
            $display("FAIL rx_glitch: pulses=%0d data_out=%02h required 0 and %02h",
                     rx_done_cnt - n0, ifc.data_out, exp_data);
        end
    endtask

    task automatic test_rx_framing();
        rx_frame(8'h55, C, C, 0, 1'b0);
        rx_frame(8'hA5, C, C, 0, 1'b1);
    endtask

    task automatic test_rx_random();
        for (int i = 0; i < 2; i++)
            rx_frame(8'($urandom), C + int'($urandom_range(40, 0)) - 20, C, 15, 1'b1);
    endtask

    task automatic loop_frame(input logic [7:0] d);
        int n0;
        n0 = rx_done_cnt;
        tx_frame(d, 1'b0, 1'b0);
        exp_data = d;
        vectors++;
        if (rx_done_cnt - n0 !== 1 || ifc.data_out !== exp_data) begin
            errors++;
            $display("FAIL loopback byte=%02h: pulses=%0d data_out=%02h required 1 and %02h",
                     d, rx_done_cnt - n0, ifc.data_out, exp_data);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_loopback();
        loop_en = 1'b1;
        loop_frame(8'h3C);
        for (int i = 0; i < 2; i++) loop_frame(8'($urandom));
    endtask

    task automatic test_reset_mid_frame();
        int ntx;
        int nrx;
        bit ok;
        loop_en = 1'b1;
        ifc.En_Tx = 1'b1;
        ifc.data_in = 8'($urandom);
        @(negedge clk);
        ifc.En_Tx = 1'b0;
        repeat ($urandom_range(4000, 500)) @(negedge clk);
        ntx = tx_done_cnt;
        nrx = rx_done_cnt;
        rst_n = 1'b0;
        exp_data = 8'h00;
        #1;
        vectors++;
        if ({ifc.serial_out, ifc.Tx_Active, ifc.Tx_Done, ifc.Rx_Done, ifc.data_out} !== {4'b1000, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_frame: line/active/txd/rxd/data=%b required 1000_00000000",
                     {ifc.serial_out, ifc.Tx_Active, ifc.Tx_Done, ifc.Rx_Done, ifc.data_out});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (ifc.serial_out !== 1'b1 || ifc.Tx_Active !== 1'b0) ok = 1'b0;
        end
        vectors++;
        if (!ok || tx_done_cnt != ntx || rx_done_cnt != nrx || ifc.data_out !== exp_data) begin
            errors++;
            $display("FAIL after_abort: idle_ok=%b txd=%0d rxd=%0d data_out=%02h required 1,0,0,00",
                     ok, tx_done_cnt - ntx, rx_done_cnt - nrx, ifc.data_out);
        end
        loop_frame(8'($urandom));
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_ignore_and_back_to_back();
        test_rx_basic();
        test_rx_glitch();
        test_rx_framing();
        test_rx_random();
        test_loopback();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_trx.md
UART_TRX -- requirements
Module: uart_trx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per bit (50 MHz / 115200 baud); legal range >= 4.
REQ-002 clk  input  1  single system clock; all state SHALL change on rising edge only.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 En_Tx  input  1  transmit request, sampled each rising clk.
REQ-005 data_in  input  8  byte to transmit, captured when a request is accepted.
REQ-006 Tx_Active  output  1  high while a frame is being transmitted.
REQ-007 serial_out  output  1  transmit line, idle high.
REQ-008 Tx_Done  output  1  one-cycle pulse at end of a transmitted frame.
REQ-009 serial_in  input  1  asynchronous receive line, idle high.
REQ-010 data_out  output  8  last correctly received byte, held until the next valid frame.
REQ-011 Rx_Done  output  1  one-cycle pulse when data_out is updated.

Function -- transmitter
REQ-012 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-013 States SHALL be IDLE, START, DATA, STOP, DONE.
REQ-014 In IDLE with En_Tx=1 at a rising edge: data_in latched, Tx_Active=1 and serial_out=0 from the next cycle.
REQ-015 En_Tx SHALL be ignored while Tx_Active=1; the latched byte SHALL NOT change mid-frame.
REQ-016 After the stop bit's CLKS_PER_BIT cycles: Tx_Active=0 and Tx_Done=1 for exactly one cycle (DONE), then IDLE.
REQ-017 serial_out SHALL be 1 in IDLE and DONE; total request-to-Tx_Done latency = 10*CLKS_PER_BIT+1 cycles.
REQ-018 En_Tx=1 in the cycle Tx_Done is high SHALL be ignored; a request in the following IDLE cycle SHALL be accepted.

Function -- receiver
REQ-019 serial_in SHALL pass through a 2-flop synchronizer (reset to 1) before use.
REQ-020 States SHALL be IDLE, START, DATA, STOP, CLEANUP.
REQ-021 IDLE: a synchronized 0 SHALL enter START and clear the bit counter.
REQ-022 START: after (CLKS_PER_BIT-1)/2 cycles sample the line; 0 -> DATA, 1 -> IDLE (glitch rejected, no outputs change).
REQ-023 DATA: sample every CLKS_PER_BIT cycles from the start-bit midpoint; bit n stored into position n (LSB first), 8 bits.
REQ-024 STOP: after a further CLKS_PER_BIT cycles sample; 1 -> data_out updated and Rx_Done=1 for one cycle; 0 -> framing error, data_out unchanged, no Rx_Done.
REQ-025 CLEANUP: wait until synchronized line is 1, then IDLE (prevents a held-low line from retriggering).
REQ-026 data_out SHALL be valid no later than 2 cycles after the stop-bit midpoint, i.e. before the nominal end of the stop bit.
REQ-027 Receiver SHALL tolerate per-bit timing error up to +/-40% of CLKS_PER_BIT accumulated over the frame, measured from the start-bit falling edge.
REQ-028 Transmitter and receiver SHALL operate fully independently and concurrently.

Reset
REQ-029 rst_n=0 SHALL immediately force: both FSMs IDLE, counters 0, serial_out=1, Tx_Active=0, Tx_Done=0, Rx_Done=0, data_out=8'h00.
REQ-030 Reset mid-frame SHALL abort the frame with no Tx_Done/Rx_Done pulse; after release, receiver SHALL wait for a fresh falling edge.

Verification
REQ-031 TX: En_Tx one-cycle pulse, data_in=8'h9F -> serial_out 0,1,1,1,1,1,0,0,1,1 each 434 cycles; Tx_Done single pulse 4341 cycles after request; Tx_Active high 4340 cycles.
REQ-032 RX: drive 8'h8F (start bit stretched +50 cycles, bits 433 cycles each, stop 1) -> data_out=8'h8F and one Rx_Done before stop-bit end.
REQ-033 Glitch: serial_in low 100 cycles then high -> no Rx_Done, data_out unchanged.
REQ-034 Framing: 8'h55 with stop bit 0, line later returns high -> no Rx_Done, data_out unchanged; next valid 8'hA5 received correctly.
REQ-035 En_Tx pulsed with data_in=8'h00 during a 8'hFF frame -> transmitted frame remains 8'hFF, only one Tx_Done.
REQ-036 Loopback serial_out->serial_in, send 8'h3C -> data_out=8'h3C; rst_n asserted mid-frame -> all outputs at reset values, no done pulses.
